// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - round-robin req/ack write arbiter owning a shared WIDTH-bit register
// Define DFF_ARB_LOCK_EN to add the lock input and up to MAX_LOCK back-to-back writes per grant.
module dff_bank_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int IDX_W    = $clog2(N_REQ),
   parameter int MAX_LOCK = 4
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ-1:0]       op_clr,
   input  logic [N_REQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
   input  logic [N_REQ-1:0]       lock,
`endif
   output logic [N_REQ-1:0]       ack,
   output logic [WIDTH-1:0]       q,
   output logic [IDX_W-1:0]       owner,
   output logic                   busy,
   output logic                   dropped
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam int                LCNT_W    = $clog2(MAX_LOCK) + 1;
   localparam logic [IDX_W:0]    N_REQ_W   = (IDX_W+1)'(N_REQ);
   localparam logic [LCNT_W-1:0] LOCK_LAST = LCNT_W'(MAX_LOCK - 1);

   state_t              state_q, state_d;
   logic [N_REQ-1:0]    ack_q, ack_d;
   logic [WIDTH-1:0]    q_q, q_d;
   logic [IDX_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    rr_q, rr_d;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
   logic                busy_q, dropped_q, dropped_d;

   logic [N_REQ-1:0]    elig, rot;
   logic [IDX_W-1:0]    win_off, winner, rr_next;
   logic [IDX_W:0]      win_sum, nxt_sum;
   logic [WIDTH-1:0]    slice;
   logic                lock_req, lock_room, hold;

   // The requester being acked right now is masked so it cannot win twice in a row.
   assign elig = req & ~ack_q;
   assign rot  = N_REQ'({elig, elig} >> rr_q);

   always_comb begin
      win_off = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) win_off = i[IDX_W-1:0];
      end
      win_sum = {1'b0, rr_q} + {1'b0, win_off};
      if (win_sum >= N_REQ_W) win_sum = win_sum - N_REQ_W;
      winner = win_sum[IDX_W-1:0];
   end

   always_comb begin
      nxt_sum = {1'b0, owner_q} + (IDX_W+1)'(1);
      if (nxt_sum >= N_REQ_W) nxt_sum = nxt_sum - N_REQ_W;
      rr_next = nxt_sum[IDX_W-1:0];
   end

   always_comb begin
      slice = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (owner_q == i[IDX_W-1:0]) slice = wdata[i*WIDTH +: WIDTH];
      end
   end

`ifdef DFF_ARB_LOCK_EN
   assign lock_req = lock[owner_q] & req[owner_q];
`else
   assign lock_req = 1'b0;
`endif
   assign lock_room = (lcnt_q < LOCK_LAST);
   assign hold      = lock_req & lock_room;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         ack_q     <= '0;
         q_q       <= '0;
         owner_q   <= '0;
         rr_q      <= '0;
         lcnt_q    <= '0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ack_q     <= ack_d;
         q_q       <= q_d;
         owner_q   <= owner_d;
         rr_q      <= rr_d;
         lcnt_q    <= lcnt_d;
         busy_q    <= (state_d == GRANT);
         dropped_q <= dropped_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|elig) state_d = GRANT;
         GRANT:   if (!hold) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      q_d       = q_q;
      ack_d     = '0;
      owner_d   = owner_q;
      rr_d      = rr_q;
      lcnt_d    = lcnt_q;
      dropped_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (|elig) owner_d = winner;
         end
         GRANT: begin
            ack_d[owner_q] = 1'b1;
            q_d            = op_clr[owner_q] ? '0 : slice;
            dropped_d      = ~clear_n;
            if (hold) begin
               lcnt_d = lcnt_q + LCNT_W'(1);
            end else begin
               lcnt_d = '0;
               rr_d   = rr_next;
            end
         end
         default: ;
      endcase
      // Synchronous clear wins over any write, granted or not.
      if (!clear_n) q_d = '0;
   end

   assign ack     = ack_q;
   assign q       = q_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign dropped = dropped_q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - directed self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        clear_n;
   logic [3:0]  req;
   logic [3:0]  op_clr;
   logic [31:0] wdata;
`ifdef DFF_ARB_LOCK_EN
   logic [3:0]  lock;
`endif
   logic [3:0]  ack;
   logic [7:0]  q;
   logic [1:0]  owner;
   logic        busy;
   logic        dropped;

   int n_cmp = 0;
   int n_bad = 0;

   dff_bank_arbiter #(.N_REQ(4), .WIDTH(8), .IDX_W(2), .MAX_LOCK(4)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .clear_n (clear_n),
      .req     (req),
      .op_clr  (op_clr),
      .wdata   (wdata),
`ifdef DFF_ARB_LOCK_EN
      .lock    (lock),
`endif
      .ack     (ack),
      .q       (q),
      .owner   (owner),
      .busy    (busy),
      .dropped (dropped)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
   endtask

   initial begin
      reset_n = 1'b0;
      clear_n = 1'b1;
      req     = '0;
      op_clr  = '0;
      wdata   = '0;
`ifdef DFF_ARB_LOCK_EN
      lock    = '0;
`endif
      step();
      chk("rst_q", q, 0);
      chk("rst_ack", ack, 0);
      chk("rst_owner", owner, 0);
      chk("rst_busy", busy, 0);
      chk("rst_dropped", dropped, 0);
      reset_n = 1'b1;

      // single write of 0xA5 from requester 0
      wdata[7:0] = 8'hA5;
      req = 4'b0001;
      step();
      chk("t1_busy", busy, 1);
      chk("t1_owner", owner, 0);
      chk("t1_ack_early", ack, 0);
      step();
      chk("t1_q", q, 8'hA5);
      chk("t1_ack", ack, 4'b0001);
      req = 4'b0000;
      step();
      chk("t1_ack_gone", ack, 0);
      chk("t1_q_hold", q, 8'hA5);

      // all four requesting: round-robin 0,1,2,3 with acks two cycles apart
      pulse_reset();
      wdata = 32'h44332211;
      req = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("rr_busy", busy, 1);
         chk("rr_owner", owner, k);
         step();
         chk("rr_ack", ack, 32'(1) << k);
         chk("rr_q", q, 8'h11 * (k + 1));
         req[k] = 1'b0;
      end
      step();
      chk("rr_idle_ack", ack, 0);
      chk("rr_idle_busy", busy, 0);

      // q=0x3C, then a clear op from requester 2
      wdata[15:8] = 8'h3C;
      req = 4'b0010;
      step();
      step();
      chk("clr_pre_q", q, 8'h3C);
      req = 4'b0100;
      op_clr = 4'b0100;
      step();
      chk("clr_owner", owner, 2);
      step();
      chk("clr_q", q, 0);
      chk("clr_ack", ack, 4'b0100);
      chk("clr_dropped", dropped, 0);
      req = '0;
      op_clr = '0;

      // clear_n low on the GRANT edge overrides the write of 0xFF
      wdata[31:24] = 8'hFF;
      req = 4'b1000;
      step();
      chk("drop_owner", owner, 3);
      clear_n = 1'b0;
      step();
      chk("drop_q", q, 0);
      chk("drop_ack", ack, 4'b1000);
      chk("drop_pulse", dropped, 1);
      clear_n = 1'b1;
      req = '0;
      step();
      chk("drop_pulse_end", dropped, 0);
      chk("drop_ack_end", ack, 0);

      // asynchronous reset in the middle of a grant
      wdata[15:8] = 8'h77;
      req = 4'b0010;
      step();
      chk("ar_busy", busy, 1);
      chk("ar_owner", owner, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("ar_q", q, 0);
      chk("ar_ack", ack, 0);
      chk("ar_owner0", owner, 0);
      chk("ar_busy0", busy, 0);
      req = '0;
      reset_n = 1'b1;
      step();
      step();
      chk("ar_no_resume_ack", ack, 0);
      chk("ar_no_resume_q", q, 0);

      // one requester holding req is re-granted two cycles after its ack
      wdata[7:0] = 8'h5A;
      req = 4'b0001;
      step();
      step();
      chk("rg_ack1", ack, 4'b0001);
      step();
      chk("rg_masked_busy", busy, 0);
      chk("rg_masked_ack", ack, 0);
      step();
      chk("rg_busy", busy, 1);
      step();
      chk("rg_ack2", ack, 4'b0001);
      req = '0;
      step();

      // requester 2 (lock/req, wdata 1..5) versus requester 0
      wdata = 32'h000100A0;
      req = 4'b0100;
`ifdef DFF_ARB_LOCK_EN
      lock = 4'b0100;
`endif
      step();
      chk("lk_owner2", owner, 2);
      req = 4'b0101;
`ifdef DFF_ARB_LOCK_EN
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("lk_ack2", ack, 4'b0100);
         chk("lk_q", q, k);
         wdata[23:16] = 8'(k + 1);
      end
      chk("lk_released", busy, 0);
      step();
      chk("lk_owner0", owner, 0);
      step();
      chk("lk_ack0", ack, 4'b0001);
      chk("lk_q0", q, 8'hA0);
`else
      step();
      chk("alt_ack2", ack, 4'b0100);
      chk("alt_q1", q, 1);
      wdata[23:16] = 8'd2;
      step();
      chk("alt_owner0", owner, 0);
      step();
      chk("alt_ack0", ack, 4'b0001);
      chk("alt_qa0", q, 8'hA0);
      req = 4'b0100;
      step();
      chk("alt_owner2", owner, 2);
      step();
      chk("alt_ack2b", ack, 4'b0100);
      chk("alt_q2", q, 2);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
